// File: rtl/gat_pkg.sv
// Shared GAT constants and the feature-reader state encoding.
package gat_pkg;

   localparam int unsigned FeatWidth = 32;
   localparam int unsigned FeatDepth = 43328;  // 2708 nodes x 16 features

   typedef enum logic [2:0] {
      StIdle,
      StWaitRdy,
      StIssue,
      StDrain,
      StDone
   } feat_rd_state_e;

endpackage

// File: rtl/gat_feat_reader_fifo.sv
// Synchronous first-word-fall-through FIFO; head word comes straight from the storage registers.
module gat_feat_reader_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             rd_fire;

   assign rd_fire  = rd_en && (count_q != '0);
   assign rd_valid = (count_q != '0);
   assign rd_data  = mem_q[rd_ptr_q];
   assign count    = count_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (rd_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CntW'(wr_en) - CntW'(rd_fire);
      end
   end

endmodule

// File: rtl/gat_feat_reader.sv
// Feature BRAM readback engine: credit-limited reads into a skid FIFO, streamed out AXI-S style.
// Optional GAT_FEAT_READER_CHECKSUM_EN adds a wrapping sum of accepted beats on `checksum`.
module gat_feat_reader
   import gat_pkg::*;
#(
   parameter int unsigned NEW_FEATURE_WIDTH  = FeatWidth,
   parameter int unsigned NEW_FEATURE_DEPTH  = FeatDepth,
   parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
   parameter int unsigned RD_LATENCY         = 2,
   parameter int unsigned FIFO_DEPTH         = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
   input  logic                          gat_ready,
   output logic                          busy,
   output logic                          done,
   output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
   output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic                          m_tlast
`ifdef GAT_FEAT_READER_CHECKSUM_EN
   ,
   output logic [31:0]                   checksum
`endif
);

   localparam int unsigned CntW = NEW_FEATURE_ADDR_W + 1;
   localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OstW = $clog2(RD_LATENCY + 1);

   feat_rd_state_e              state_q, state_d;
   logic [CntW-1:0]             count_q, idx_q, beat_q;
   logic [NEW_FEATURE_ADDR_W+1:0] addr_q;
   logic [RD_LATENCY-1:0]       vpipe_q;
   logic [OstW-1:0]             outst_q;
   logic [OccW-1:0]             occ;
   logic                        credit_ok, issue, last_issue, rd_exit, pop, drain_done;

   // Reads in flight plus words already buffered must fit in the FIFO.
   assign credit_ok  = (32'(outst_q) + 32'(occ)) < FIFO_DEPTH;
   assign issue      = (state_q == StIssue) && credit_ok;
   assign last_issue = issue && (idx_q == count_q - CntW'(1));
   assign rd_exit    = vpipe_q[RD_LATENCY-1];
   assign pop        = m_tvalid && m_tready;
   assign m_tlast    = m_tvalid && (beat_q == count_q - CntW'(1));
   assign drain_done = pop && m_tlast && (outst_q == '0) && (occ == OccW'(1));

   assign busy            = (state_q != StIdle);
   assign done            = (state_q == StDone);
   assign feat_bram_addrb = issue ? {idx_q[NEW_FEATURE_ADDR_W-1:0], 2'b00} : addr_q;

   gat_feat_reader_fifo #(
      .WIDTH (NEW_FEATURE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (rd_exit),
      .wr_data  (feat_bram_dout),
      .rd_en    (pop),
      .rd_data  (m_tdata),
      .rd_valid (m_tvalid),
      .count    (occ)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start) state_d = StWaitRdy;
         StWaitRdy: if (gat_ready) state_d = (count_q == '0) ? StDone : StIssue;
         StIssue:   if (last_issue) state_d = StDrain;
         StDrain:   if (drain_done) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         idx_q   <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         vpipe_q <= '0;
         outst_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && start) begin
            count_q <= (num_words > CntW'(NEW_FEATURE_DEPTH)) ? CntW'(NEW_FEATURE_DEPTH)
                                                             : num_words;
            idx_q   <= '0;
            beat_q  <= '0;
         end
         if (issue) begin
            idx_q  <= idx_q + CntW'(1);
            addr_q <= {idx_q[NEW_FEATURE_ADDR_W-1:0], 2'b00};
         end
         if (pop) beat_q <= beat_q + CntW'(1);
         vpipe_q[0] <= issue;
         for (int i = 1; i < RD_LATENCY; i++) vpipe_q[i] <= vpipe_q[i-1];
         outst_q <= outst_q + OstW'(issue) - OstW'(rd_exit);
      end
   end

`ifdef GAT_FEAT_READER_CHECKSUM_EN
   logic [31:0] checksum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= '0;
      end else if (state_q == StIdle && start) begin
         checksum_q <= '0;
      end else if (pop) begin
         checksum_q <= checksum_q + 32'(m_tdata);
      end
   end

   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_gat_feat_reader.sv
// Directed bench for gat_feat_reader with a latency-matched BRAM model and a stream monitor.
module tb_gat_feat_reader;

   localparam int unsigned Depth = 43328;
   localparam int unsigned Aw    = 16;
   localparam int unsigned Lat   = 2;
   localparam int unsigned Fd    = 4;

   logic          clk, rst, start, gat_ready, busy, done, m_tvalid, m_tready, m_tlast;
   logic [Aw:0]   num_words;
   logic [Aw+1:0] feat_bram_addrb;
   logic [31:0]   feat_bram_dout, m_tdata;
`ifdef GAT_FEAT_READER_CHECKSUM_EN
   logic [31:0]   checksum, cks_at_done;
`endif

   gat_feat_reader dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .num_words       (num_words),
      .gat_ready       (gat_ready),
      .busy            (busy),
      .done            (done),
      .feat_bram_addrb (feat_bram_addrb),
      .feat_bram_dout  (feat_bram_dout),
      .m_tdata         (m_tdata),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .m_tlast         (m_tlast)
`ifdef GAT_FEAT_READER_CHECKSUM_EN
      ,
      .checksum        (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0       = 0;
   int ready_pct = 100;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model with the same read latency the DUT is configured for
   logic [31:0] bram [Depth];
   logic [31:0] rdp  [Lat];
   always @(posedge clk) begin
      rdp[0] <= bram[feat_bram_addrb[Aw+1:2]];
      for (int i = 1; i < Lat; i++) rdp[i] <= rdp[i-1];
   end
   assign feat_bram_dout = rdp[Lat-1];

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   logic [31:0] beats [$];
   logic        blast [$];
   int          bcyc  [$];
   int          done_cnt, done_cyc, stab_err, ovf_err;
   logic        pv, pr;
   logic [31:0] pd;

   always @(negedge clk) begin
      if (m_tvalid && m_tready) begin
         beats.push_back(m_tdata);
         blast.push_back(m_tlast);
         bcyc.push_back(cyc - t0);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc - t0;
`ifdef GAT_FEAT_READER_CHECKSUM_EN
         cks_at_done = checksum;
`endif
      end
      if (!rst && pv && !pr && (!m_tvalid || m_tdata !== pd)) stab_err = stab_err + 1;
      pv = m_tvalid;
      pr = m_tready;
      pd = m_tdata;
      if (dut.u_fifo.count_q > Fd) ovf_err = ovf_err + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [31:0] base);
      for (int i = 0; i < Depth; i++) bram[i] = base + 32'(i);
   endtask

   // g: cycle in which gat_ready is (or already was) high; abort_at: reset after that many beats
   task automatic xfer(input string name, input int n, input int pct, input int g,
                       input int abort_at, input logic [31:0] base);
      int          exp_n, budget, wait_errs, last_idx, n_last, data_errs, addr_probe;
      logic [31:0] sum;
      logic [Aw+1:0] addr0;
      logic        timed_out;
      exp_n = (n > int'(Depth)) ? int'(Depth) : n;
      beats.delete();
      blast.delete();
      bcyc.delete();
      done_cnt   = 0;
      done_cyc   = -1;
      stab_err   = 0;
      ovf_err    = 0;
      wait_errs  = 0;
      addr_probe = -1;
      timed_out  = 1'b0;
      ready_pct  = pct;
      gat_ready  = (g <= 1);
      start      = 1'b1;
      num_words  = (Aw+1)'(n);
      t0         = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({name, ":busy_c1"}, busy, 1);
      addr0 = feat_bram_addrb;
      while (cyc - t0 < g) begin
         if (!busy || feat_bram_addrb !== addr0) wait_errs++;
         @(posedge clk);
         #1;
      end
      gat_ready = 1'b1;
      if (g > 1) check({name, ":wait_idle_addr"}, wait_errs, 0);
      budget = exp_n * 20 + 200;
      while (done_cnt == 0) begin
         if (cyc - t0 == g + 2) addr_probe = int'(feat_bram_addrb);
         if (pct < 100 && cyc - t0 == g + 5) gat_ready = 1'b0;
         if (abort_at > 0 && beats.size() >= abort_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check({name, ":rst_busy"}, busy, 0);
            check({name, ":rst_tvalid"}, m_tvalid, 0);
            check({name, ":rst_tdata"}, m_tdata, 0);
            return;
         end
         if (cyc - t0 > budget) begin
            timed_out = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check({name, ":timeout"}, timed_out, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check({name, ":idle_after"}, busy, 0);
      check({name, ":done_pulses"}, done_cnt, 1);
      check({name, ":beats"}, beats.size(), exp_n);
      data_errs = 0;
      n_last    = 0;
      last_idx  = -1;
      sum       = '0;
      for (int i = 0; i < exp_n; i++) sum = sum + base + 32'(i);
      for (int i = 0; i < beats.size(); i++) begin
         if (beats[i] !== base + 32'(i)) data_errs++;
         if (blast[i]) begin
            n_last++;
            if (last_idx < 0) last_idx = i;
         end
      end
      check({name, ":data_errs"}, data_errs, 0);
      check({name, ":n_last"}, n_last, (exp_n > 0) ? 1 : 0);
      check({name, ":stable"}, stab_err, 0);
      check({name, ":fifo_ovf"}, ovf_err, 0);
      if (exp_n > 0 && beats.size() > 0) begin
         check({name, ":last_idx"}, last_idx, exp_n - 1);
         check({name, ":first_beat_cyc"}, bcyc[0], g + 4);
         check({name, ":done_cyc"}, done_cyc, bcyc[bcyc.size()-1] + 1);
         check({name, ":last_addr"}, feat_bram_addrb, 4 * (exp_n - 1));
         if (pct == 100) check({name, ":last_beat_cyc"}, bcyc[bcyc.size()-1], g + 3 + exp_n);
      end else begin
         check({name, ":done_cyc0"}, done_cyc, g + 1);
      end
      if (exp_n >= 2) check({name, ":second_addr"}, addr_probe, 4);
`ifdef GAT_FEAT_READER_CHECKSUM_EN
      check({name, ":checksum"}, cks_at_done, sum);
`else
      if (sum == 32'hFFFF_FFFF) sum = '0;
`endif
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      gat_ready = 1'b0;
      num_words = '0;
      done_cnt  = 0;
      stab_err  = 0;
      ovf_err   = 0;
      pv        = 1'b0;
      pr        = 1'b0;
      pd        = '0;
      for (int i = 0; i < Lat; i++) rdp[i] = '0;
      fill(32'h1000);
      repeat (3) @(posedge clk);
      #1;
      check("reset:busy", busy, 0);
      check("reset:done", done, 0);
      check("reset:tvalid", m_tvalid, 0);
      check("reset:tlast", m_tlast, 0);
      check("reset:tdata", m_tdata, 0);
      check("reset:addrb", feat_bram_addrb, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      xfer("basic", 16, 100, 1, 0, 32'h1000);
      xfer("backpressure", 100, 30, 1, 0, 32'h1000);
      xfer("wait_core", 8, 100, 51, 0, 32'h1000);
      xfer("zero", 0, 100, 1, 0, 32'h1000);
      xfer("abort", 32, 100, 1, 7, 32'h1000);
      xfer("restart", 4, 100, 1, 0, 32'h1000);
      xfer("full", int'(Depth) + 5, 100, 1, 0, 32'h1000);
`ifdef GAT_FEAT_READER_CHECKSUM_EN
      fill(32'd1);
      xfer("checksum", 10, 100, 1, 0, 32'd1);
      check("checksum:value55", cks_at_done, 55);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gat_feat_reader.md
# gat_feat_reader

Host-side readback engine for the GAT accelerator's output feature BRAM. After the core raises `gat_ready`, the reader walks the feature BRAM read port with 4-byte-aligned byte addresses. It absorbs the BRAM read latency and streams each 32-bit feature word out on an AXI-Stream-style master port. It is the consumer end of the `feat_bram_addrb`/`feat_bram_dout` interface and sits between the GAT top and the PS/DMA path in the block design.

## Interface
- `NEW_FEATURE_WIDTH`, 32: feature word width, equal to the stream data width.
- `NEW_FEATURE_DEPTH`, 43328: number of words in the feature BRAM (2708 × 16).
- `NEW_FEATURE_ADDR_W`, `$clog2(NEW_FEATURE_DEPTH)`: word address width.
- `RD_LATENCY`, 2: cycles from `feat_bram_addrb` to valid `feat_bram_dout`; allowed range 1–4.
- `FIFO_DEPTH`, 4: skid FIFO depth; must be at least `RD_LATENCY`+2.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `start`, in, 1: one-cycle request; sampled only in IDLE.
- `num_words`, in, `NEW_FEATURE_ADDR_W`+1: word count, latched on `start`.
- `gat_ready`, in, 1: core results are valid.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the transfer completes.
- `feat_bram_addrb`, out, `NEW_FEATURE_ADDR_W`+2: byte address; bits [1:0] are always 0.
- `feat_bram_dout`, in, `NEW_FEATURE_WIDTH`: BRAM read data.
- `m_tdata`, out, `NEW_FEATURE_WIDTH`: stream data.
- `m_tvalid`, out, 1: stream data valid.
- `m_tready`, in, 1: downstream ready.
- `m_tlast`, out, 1: marks the final word.

## Operation
- States:
  - IDLE → WAIT_RDY on `start`.
  - WAIT_RDY → ISSUE when `gat_ready`=1. If the latched count is 0, go to DONE instead.
  - ISSUE → DRAIN after the last address is issued.
  - DRAIN → DONE when the outstanding count is 0, the FIFO is empty and the last beat has been accepted.
  - DONE → IDLE unconditionally. `done`=1 only in DONE.
- Latched count: `num_words` is clamped to `NEW_FEATURE_DEPTH`.
- Address generation: word index starts at 0 and increments by 1 per issue. `feat_bram_addrb` = {index, 2'b00}.
- Credit rule:
  - A read is issued in ISSUE only when outstanding reads plus FIFO occupancy is less than `FIFO_DEPTH`.
  - This guarantees the FIFO never overflows.
- Read-valid tracking: a `RD_LATENCY`-deep shift register carries each read's valid bit. When a valid bit exits the shift register, `feat_bram_dout` is written into the FIFO.
- Stream output:
  - `m_tdata`/`m_tvalid` come from the FIFO head.
  - `m_tlast` = 1 when the head word is the final word (beats accepted = count−1).
  - Words are emitted in address order. No word is dropped or duplicated.
- Ignored inputs:
  - `start` while `busy` is ignored.
  - `gat_ready` is ignored outside WAIT_RDY; deassertion mid-transfer has no effect.
- Reset: `rst` at any point returns the block to IDLE, flushes the FIFO and the valid pipe, and discards in-flight BRAM data.
- Reset values: `busy`=0, `done`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `feat_bram_addrb`=0.

## Timing
- Cycle reference: `start` is sampled at cycle 0, WAIT_RDY is entered at cycle 1, and if `gat_ready`=1, ISSUE is entered at cycle 2.
- First read and first beat: the first address is driven at cycle 2. The first `m_tvalid` appears at cycle 3+`RD_LATENCY` (cycle 5 by default).
- Throughput: with `m_tready` held at 1, one word per cycle sustained.
- `tvalid` stability: once asserted, `m_tvalid` and `m_tdata` hold until `m_tready`=1.
- Completion: `done` pulses in the cycle after the handshake of the `m_tlast` beat. For a count of 0, `done` pulses at cycle 2 with no beats.
- Back-pressure: when `m_tready` is low, issue stalls by credit within `FIFO_DEPTH` cycles. The address holds its last issued value.
- Simultaneous FIFO write and read in the same cycle are both honoured; occupancy is unchanged.

## Configuration
- Macro: `GAT_FEAT_READER_CHECKSUM_EN`.
- When defined:
  - Adds output `checksum` (32 bits): the wrapping sum of all accepted beats.
  - `checksum` clears on `start` and is valid when `done`=1.
  - `rst` sets it to 0.
- When undefined: the port and its logic do not exist, and behaviour is otherwise identical.

## Structure
- `gat_pkg`: the state enum (IDLE, WAIT_RDY, ISSUE, DRAIN, DONE) and the feature depth/width constants shared with `gat_top`.
- Sub-module `gat_feat_reader_fifo`: synchronous first-word-fall-through FIFO with registered head and occupancy count, parameterised by width and depth.

## Test plan
- Basic transfer: BRAM preloaded with word i = 0x1000+i; `num_words`=16, `gat_ready`=1, `m_tready`=1 → 16 beats 0x1000..0x100F on consecutive cycles, first `m_tvalid` at cycle 5, `m_tlast` only on 0x100F, `done` one cycle later.
- Random back-pressure: `m_tready` random at 30% duty, `num_words`=100 → exact in-order sequence, no loss or duplication, FIFO never overflows (assertion).
- Wait for core: `gat_ready` held low for 50 cycles after `start` → no address issued and `busy`=1 throughout; the first read issues 1 cycle after `gat_ready` rises.
- Degenerate counts: `num_words`=0 → `done` at cycle 2 with no beats. `num_words`=`NEW_FEATURE_DEPTH`+5 → exactly 43328 beats, last address 0x2A4FC.
- Reset mid-transfer: `rst` at beat 7 of 32, then a new `start` with count 4 → the stream restarts at word 0 with 4 beats and no stale data.
- Checksum (with `GAT_FEAT_READER_CHECKSUM_EN`): words 1..10 → `checksum`=55 at `done`.
